// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and request payload type for the write-back port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned RIDX_W_DEF = 5;
  localparam int unsigned WB_NUM_REQ = 3;

  // Producer-side request bundle, flattened into the arbiter's request vectors
  typedef struct packed {
    logic                  valid;
    logic [RIDX_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_req_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request after ptr_i, wrapping.
module rr_pick
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]            req_i,
  input  logic [idx_width(N)-1:0] ptr_i,
  output logic [N-1:0]            gnt_o,
  output logic [idx_width(N)-1:0] idx_o,
  output logic                    any_o
);

  localparam int unsigned IW = idx_width(N);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned j;
      j = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the RF write port, with a one-entry output stage.
// Optional WB_ARB_STATS_EN adds conflict/stall counters.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = WB_NUM_REQ,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RIDX_W  = RIDX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*RIDX_W-1:0]  req_rd,
  input  logic [NUM_REQ*XLEN-1:0]    req_data,
  output logic                       rf_we,
  output logic [RIDX_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic                       rf_wr_ready,
`ifdef WB_ARB_STATS_EN
  output logic [31:0]                conflict_cnt,
  output logic [31:0]                stall_cnt,
`endif
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic              out_valid_q, out_valid_d;
  logic [RIDX_W-1:0] out_rd_q, out_rd_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]    out_id_q, out_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               can_load_c, drain_c, accept_c;
  logic [RIDX_W-1:0]  sel_rd_c;
  logic [XLEN-1:0]    sel_data_c;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign can_load_c = !out_valid_q || rf_wr_ready;
  assign drain_c    = out_valid_q && rf_wr_ready;
  assign accept_c   = pick_any && can_load_c;
  assign req_ready  = can_load_c ? pick_gnt : '0;

  // Mux the winner's payload out of the flattened request vectors
  always_comb begin
    sel_rd_c   = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_rd_c   = req_rd[i*RIDX_W +: RIDX_W];
        sel_data_c = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept_c) begin
      rr_ptr_d = pick_idx;
      if (sel_rd_c != '0) begin
        out_valid_d = 1'b1;
        out_rd_d    = sel_rd_c;
        out_data_d  = sel_data_c;
        out_id_d    = pick_idx;
      end else if (drain_c) begin
        // x0 writes are consumed but never reach the RF
        out_valid_d = 1'b0;
      end
    end else if (drain_c) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rf_we    = out_valid_q;
  assign rf_waddr = out_rd_q;
  assign rf_wdata = out_data_q;
  assign grant_id = out_id_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_q;
  logic [31:0] stall_q;

  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if ($countones(req_valid) > 1) conflict_q <= conflict_q + 32'd1;
      if (out_valid_q && !rf_wr_ready) stall_q <= stall_q + 32'd1;
    end
  end

  assign conflict_cnt = conflict_q;
  assign stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed requests, queued expected RF writes.
module tb_wb_port_arbiter;

  localparam int NR = 3;
  localparam int XL = 32;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_rd;
  logic [NR*XL-1:0]  req_data;
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [XL-1:0]     rf_wdata;
  logic              rf_wr_ready;
  logic [1:0]        grant_id;
`ifdef WB_ARB_STATS_EN
  logic [31:0]       conflict_cnt;
  logic [31:0]       stall_cnt;
`endif

  wb_port_arbiter #(.NUM_REQ(NR), .XLEN(XL), .RIDX_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wr_ready (rf_wr_ready),
`ifdef WB_ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [XL-1:0] data;
  } item_t;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [XL-1:0] data;
    logic [1:0]    id;
  } exp_t;

  item_t rq [NR][$];
  exp_t  expq [$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  int    acc_cnt [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic add_req(input int i, input logic [RW-1:0] rd, input logic [XL-1:0] data);
    item_t it;
    it.rd = rd;
    it.data = data;
    rq[i].push_back(it);
  endtask

  task automatic expect_wr(input logic [1:0] id, input logic [RW-1:0] rd, input logic [XL-1:0] data);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.data = data;
    expq.push_back(e);
  endtask

  // Each requester presents its queue head and holds it until accepted
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_rd[i*RW +: RW] = rq[i][0].rd;
        req_data[i*XL +: XL] = rq[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_rd[i*RW +: RW] = '0;
        req_data[i*XL +: XL] = '0;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] fire;
    logic [NR-1:0] held_v;
    logic [NR*RW-1:0] held_rd;
    logic [NR*XL-1:0] held_data;
    item_t tmp;
    @(negedge clk);
    fire = req_valid & req_ready;
    held_v = req_valid & ~fire;
    held_rd = req_rd;
    held_data = req_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        tmp = rq[i].pop_front();
        acc_cnt[i]++;
      end
    end
    drive();
    for (int i = 0; i < NR; i++) begin
      if (held_v[i] && (!req_valid[i] || req_rd[i*RW +: RW] != held_rd[i*RW +: RW]
                        || req_data[i*XL +: XL] != held_data[i*XL +: XL]))
        $display("FAIL requester_hold: req %0d changed before accept", i);
    end
  endtask

  function automatic bit pending();
    bit p = (expq.size() != 0);
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int max_cycles);
    for (int n = 0; n < max_cycles && pending(); n++) tick();
    check({name, "_drained"}, 64'(expq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_wr_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      acc_cnt[i] = 0;
    end
    expq.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every RF write the DUT completes must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && rf_we && rf_wr_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h id %0d, expected no write", rf_waddr, rf_wdata, grant_id);
      end else begin
        mon_e = expq.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(mon_e.rd));
        check("wr_data", 64'(rf_wdata), 64'(mon_e.data));
        check("wr_grant_id", 64'(grant_id), 64'(mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rf_wr_ready = 1'b1;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
    drive();
    #12;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single requester 1
    add_req(1, 5'd7, 32'hDEADBEEF);
    expect_wr(2'd1, 5'd7, 32'hDEADBEEF);
    drive();
    #1 check("t1_ready", 64'(req_ready), 64'b010);
    tick();
    check("t1_latency_we", 64'(rf_we), 64'd1);
    check("t1_grant_id", 64'(grant_id), 64'd1);
    wait_drain("t1", 20);

    // All three continuously valid: 0,1,2,0,1,2 back to back
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        add_req(i, 5'(1 + i + 3*k), 32'hA000_0000 + 32'(i + 3*k));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        expect_wr(2'(i), 5'(1 + i + 3*k), 32'hA000_0000 + 32'(i + 3*k));
    drive();
    repeat (7) tick();
    check("t2_no_bubble", 64'(expq.size()), 64'd0);
    check("t2_acc0", 64'(acc_cnt[0]), 64'd2);
    check("t2_acc2", 64'(acc_cnt[2]), 64'd2);

    // Backpressure for four cycles with an entry held in the output stage
    do_reset();
    rf_wr_ready = 1'b0;
    add_req(0, 5'd8, 32'h8888_0008);
    add_req(1, 5'd9, 32'h9999_0009);
    expect_wr(2'd0, 5'd8, 32'h8888_0008);
    expect_wr(2'd1, 5'd9, 32'h9999_0009);
    drive();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t3_ready_zero", 64'(req_ready), 64'd0);
      check("t3_we_held", 64'(rf_we), 64'd1);
      check("t3_waddr_stable", 64'(rf_waddr), 64'd8);
      check("t3_wdata_stable", 64'(rf_wdata), 64'h8888_0008);
      tick();
    end
`ifdef WB_ARB_STATS_EN
    check("t3_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    rf_wr_ready = 1'b1;
    wait_drain("t3", 20);

    // x0 write from requester 2 is accepted and dropped, pointer still advances
    do_reset();
    add_req(0, 5'd12, 32'h0000_00C0);
    expect_wr(2'd0, 5'd12, 32'h0000_00C0);
    drive();
    tick();
    add_req(2, 5'd0, 32'h0000_1234);
    drive();
    #1 check("t4_x0_ready", 64'(req_ready), 64'b100);
    tick();
    check("t4_no_we", 64'(rf_we), 64'd0);
    add_req(0, 5'd11, 32'h0000_00B0);
    add_req(1, 5'd10, 32'h0000_00B1);
    expect_wr(2'd0, 5'd11, 32'h0000_00B0);
    expect_wr(2'd1, 5'd10, 32'h0000_00B1);
    drive();
    #1 check("t4_next_from0", 64'(req_ready), 64'b001);
    wait_drain("t4", 20);

    // Requesters 0 and 1 contend for ten cycles
    do_reset();
    for (int k = 0; k < 6; k++) begin
      add_req(0, 5'(16 + k), 32'hC000_0000 + 32'(k));
      add_req(1, 5'(24 + k), 32'hD000_0000 + 32'(k));
    end
    for (int k = 0; k < 6; k++) begin
      expect_wr(2'd0, 5'(16 + k), 32'hC000_0000 + 32'(k));
      expect_wr(2'd1, 5'(24 + k), 32'hD000_0000 + 32'(k));
    end
    drive();
    repeat (10) tick();
    check("t5_acc0", 64'(acc_cnt[0]), 64'd5);
    check("t5_acc1", 64'(acc_cnt[1]), 64'd5);
`ifdef WB_ARB_STATS_EN
    check("t5_conflict_cnt", 64'(conflict_cnt), 64'd10);
`endif
    wait_drain("t5", 20);

    // Asynchronous reset with a pending output write
    do_reset();
    rf_wr_ready = 1'b0;
    add_req(0, 5'd3, 32'h0000_00DD);
    drive();
    tick();
    check("t6_pending_we", 64'(rf_we), 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_async_we", 64'(rf_we), 64'd0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    expq.delete();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    rf_wr_ready = 1'b1;
    for (int i = 0; i < NR; i++) add_req(i, 5'(20 + i), 32'hE000_0000 + 32'(i));
    for (int i = 0; i < NR; i++) expect_wr(2'(i), 5'(20 + i), 32'hE000_0000 + 32'(i));
    drive();
    #1 check("t6_first_winner", 64'(req_ready), 64'b001);
    wait_drain("t6", 20);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
